// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the memory-stage FSM encoding.
package cpu_types_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } memstate_t;

endpackage

// File: rtl/mem_access_if.sv
// Data-cache request/response bus between the MEM stage (master) and the cache (slave).
interface mem_access_if;
    import cpu_types_pkg::*;

    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  dhit;
    word_t dload;

    modport master (output dREN, dWEN, daddr, dstore, input dhit, dload);
    modport slave  (input dREN, dWEN, daddr, dstore, output dhit, dload);
endinterface

// File: rtl/mem_access_link_reg.sv
// Load-linked reservation register; only instantiated when LLSC_EN is defined.
module link_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  set,
    input  word_t set_addr,
    input  logic  store_done,
    input  word_t store_addr,
    input  logic  snoop_inv,
    input  word_t snoop_addr,
    output logic  link_valid,
    output word_t link_addr
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (set) begin
            // An invalidate racing the LL completion for the same line kills the new link.
            link_valid <= !(snoop_inv && snoop_addr == set_addr);
            link_addr  <= set_addr;
        end else if ((store_done && store_addr == link_addr) ||
                     (snoop_inv && snoop_addr == link_addr)) begin
            link_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage data-cache sequencer (IDLE -> ACCESS -> DONE) with pipeline stall control.
// Define LLSC_EN to add load-linked/store-conditional support and the snoop ports.
module mem_access
    import cpu_types_pkg::*;
(
    input  logic         CLK,
    input  logic         nRST,
    input  logic         ex_valid,
    input  logic         ex_memRead,
    input  logic         ex_memWrite,
    input  word_t        ex_addr,
    input  word_t        ex_storeData,
    mem_access_if.master dbus,
    output logic         wb_writeEN,
    output word_t        wb_dmemload,
    output logic         stall_up,
    output logic         protocol_err
`ifdef LLSC_EN
    ,
    input  logic         ex_ll,
    input  logic         ex_sc,
    input  logic         ccinv,
    input  word_t        ccsnoopaddr,
    output logic         wb_scResult
`endif
);

    memstate_t state, next_state;
    logic      mem_req;
    logic      both_req;
    logic      req_wr;
    logic      op_wr;
    logic      dren, dwen;
    word_t     daddr_q, dstore_q;

`ifdef LLSC_EN
    logic  op_ll, op_sc;
    logic  sc_ok;
    logic  link_valid;
    word_t link_addr;
    logic  link_set, link_store;
`endif

    // A failing SC never reaches the cache; it retires from IDLE like an ALU op.
    always_comb begin
        mem_req  = ex_valid && (ex_memRead || ex_memWrite);
        both_req = ex_valid && ex_memRead && ex_memWrite;
        req_wr   = ex_memWrite;
`ifdef LLSC_EN
        sc_ok = link_valid && (link_addr == ex_addr) &&
                !(ccinv && ccsnoopaddr == link_addr);
        if (ex_valid && ex_ll) mem_req = 1'b1;
        if (ex_valid && ex_sc) begin
            mem_req = sc_ok;
            req_wr  = 1'b1;
        end
        if (!mem_req) both_req = 1'b0;
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (mem_req)   next_state = ACCESS;
            ACCESS:  if (dbus.dhit) next_state = DONE;
            DONE:                   next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_comb begin
        dren       = 1'b0;
        dwen       = 1'b0;
        stall_up   = 1'b0;
        wb_writeEN = 1'b0;
        unique case (state)
            IDLE: begin
                stall_up   = mem_req;
                wb_writeEN = !mem_req;
            end
            ACCESS: begin
                dren     = !op_wr;
                dwen     = op_wr;
                stall_up = 1'b1;
            end
            DONE:    wb_writeEN = 1'b1;
            default: ;
        endcase
    end

    // Request latch on acceptance, load capture on completion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            daddr_q      <= '0;
            dstore_q     <= '0;
            op_wr        <= 1'b0;
            wb_dmemload  <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (state == IDLE && mem_req) begin
                daddr_q  <= ex_addr;
                dstore_q <= ex_storeData;
                op_wr    <= req_wr;
                if (both_req) protocol_err <= 1'b1;
            end
            if (state == ACCESS && dbus.dhit && !op_wr) wb_dmemload <= dbus.dload;
        end
    end

    assign dbus.dREN   = dren;
    assign dbus.dWEN   = dwen;
    assign dbus.daddr  = daddr_q;
    assign dbus.dstore = dstore_q;

`ifdef LLSC_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op_ll <= 1'b0;
            op_sc <= 1'b0;
        end else if (state == IDLE && mem_req) begin
            op_ll <= ex_ll;
            op_sc <= ex_sc;
        end
    end

    assign link_set    = (state == DONE) && op_ll;
    assign link_store  = (state == DONE) && op_wr;
    assign wb_scResult = (state == DONE) && op_sc;

    link_reg u_link_reg (
        .CLK        (CLK),
        .nRST       (nRST),
        .set        (link_set),
        .set_addr   (daddr_q),
        .store_done (link_store),
        .store_addr (daddr_q),
        .snoop_inv  (ccinv),
        .snoop_addr (ccsnoopaddr),
        .link_valid (link_valid),
        .link_addr  (link_addr)
    );
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus random instruction mix vs a transaction model.
module tb_mem_access;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  ex_valid, ex_memRead, ex_memWrite;
  word_t ex_addr, ex_storeData;
  logic  wb_writeEN, stall_up, protocol_err;
  word_t wb_dmemload;
`ifdef LLSC_EN
  logic  ex_ll, ex_sc, ccinv, wb_scResult;
  word_t ccsnoopaddr;
`endif

  int    n_chk = 0;
  int    n_fail = 0;
  word_t model_load = '0;
  logic  model_perr = 1'b0;

  mem_access_if dbus ();

  mem_access dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ex_valid     (ex_valid),
    .ex_memRead   (ex_memRead),
    .ex_memWrite  (ex_memWrite),
    .ex_addr      (ex_addr),
    .ex_storeData (ex_storeData),
    .dbus         (dbus),
    .wb_writeEN   (wb_writeEN),
    .wb_dmemload  (wb_dmemload),
    .stall_up     (stall_up),
    .protocol_err (protocol_err)
`ifdef LLSC_EN
    ,
    .ex_ll        (ex_ll),
    .ex_sc        (ex_sc),
    .ccinv        (ccinv),
    .ccsnoopaddr  (ccsnoopaddr),
    .wb_scResult  (wb_scResult)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One non-memory (or bubble) cycle: retires immediately, nothing on the bus.
  task automatic alu(input logic valid, input logic snoop, input word_t snoop_a);
    tick();
    ex_valid     = valid;
    ex_memRead   = valid ? 1'b0 : 1'($urandom_range(0, 1));
    ex_memWrite  = valid ? 1'b0 : 1'($urandom_range(0, 1));
    ex_addr      = $urandom;
    ex_storeData = $urandom;
    dbus.dhit    = 1'($urandom_range(0, 1));
    dbus.dload   = $urandom;
`ifdef LLSC_EN
    ex_ll = 1'b0; ex_sc = 1'b0; ccinv = snoop; ccsnoopaddr = snoop_a;
`else
    if (snoop && snoop_a == '0) dbus.dload = '0;
`endif
    #1;
    chk("alu_wben",  wb_writeEN, 1'b1);
    chk("alu_stall", stall_up, 1'b0);
    chk("alu_dren",  dbus.dREN, 1'b0);
    chk("alu_dwen",  dbus.dWEN, 1'b0);
    chk("alu_load",  wb_dmemload, model_load);
    chk("alu_perr",  protocol_err, model_perr);
  endtask

  // One memory transaction; the cache answers on the lat-th access cycle.
  task automatic do_mem(input logic rd, input logic wr, input logic ll, input logic sc,
                        input word_t addr, input word_t data, input int lat, input word_t rdata);
    logic exp_w, exp_rd;
    exp_w  = wr | sc;
    exp_rd = (rd | ll) & !exp_w;
    tick();
    ex_valid = 1'b1; ex_memRead = rd; ex_memWrite = wr;
    ex_addr = addr; ex_storeData = data;
    dbus.dhit = 1'($urandom_range(0, 1)); dbus.dload = $urandom;
`ifdef LLSC_EN
    ex_ll = ll; ex_sc = sc; ccinv = 1'b0; ccsnoopaddr = '0;
`endif
    #1;
    chk("req_stall", stall_up, 1'b1);
    chk("req_wben",  wb_writeEN, 1'b0);
    chk("req_dren",  dbus.dREN, 1'b0);
    chk("req_dwen",  dbus.dWEN, 1'b0);
    chk("req_perr",  protocol_err, model_perr);
    if (rd && wr) model_perr = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      tick();
      dbus.dhit  = (k == lat);
      dbus.dload = (k == lat) ? rdata : word_t'($urandom);
      #1;
      chk("acc_dren",   dbus.dREN, exp_rd);
      chk("acc_dwen",   dbus.dWEN, exp_w);
      chk("acc_daddr",  dbus.daddr, addr);
      chk("acc_dstore", dbus.dstore, data);
      chk("acc_stall",  stall_up, 1'b1);
      chk("acc_wben",   wb_writeEN, 1'b0);
      chk("acc_perr",   protocol_err, model_perr);
    end
    if (exp_rd) model_load = rdata;
    tick();
    dbus.dhit = 1'($urandom_range(0, 1)); dbus.dload = $urandom;
    #1;
    chk("done_wben",  wb_writeEN, 1'b1);
    chk("done_stall", stall_up, 1'b0);
    chk("done_dren",  dbus.dREN, 1'b0);
    chk("done_dwen",  dbus.dWEN, 1'b0);
    chk("done_load",  wb_dmemload, model_load);
`ifdef LLSC_EN
    chk("done_sc",    wb_scResult, sc);
`endif
  endtask

`ifdef LLSC_EN
  // SC whose link is missing or snooped away this very cycle: no access, retires at once.
  task automatic sc_fail(input word_t addr, input logic snoop);
    tick();
    ex_valid = 1'b1; ex_memRead = 1'b0; ex_memWrite = 1'b1;
    ex_addr = addr; ex_storeData = $urandom; ex_ll = 1'b0; ex_sc = 1'b1;
    ccinv = snoop; ccsnoopaddr = addr; dbus.dhit = 1'b0;
    #1;
    chk("scf_wben",  wb_writeEN, 1'b1);
    chk("scf_stall", stall_up, 1'b0);
    chk("scf_dwen",  dbus.dWEN, 1'b0);
    chk("scf_res",   wb_scResult, 1'b0);
  endtask
`endif

  initial begin
    nRST = 1'b0;
    ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0;
    ex_addr = '0; ex_storeData = '0;
    dbus.dhit = 1'b0; dbus.dload = '0;
`ifdef LLSC_EN
    ex_ll = 1'b0; ex_sc = 1'b0; ccinv = 1'b0; ccsnoopaddr = '0;
`endif
    #1;
    chk("rst_dren",   dbus.dREN, 1'b0);
    chk("rst_dwen",   dbus.dWEN, 1'b0);
    chk("rst_daddr",  dbus.daddr, 32'h0);
    chk("rst_dstore", dbus.dstore, 32'h0);
    chk("rst_load",   wb_dmemload, 32'h0);
    chk("rst_perr",   protocol_err, 1'b0);
    chk("rst_stall",  stall_up, 1'b0);
    chk("rst_wben",   wb_writeEN, 1'b1);
    tick();
    tick();
    nRST = 1'b1;

    // Load with dhit after two access cycles, then a store answered at once.
    do_mem(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    do_mem(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h1234, 1, 32'hCAFEF00D);
    // ALU, load, ALU with minimum latency; bubbles must not trigger access.
    alu(1'b1, 1'b0, '0);
    do_mem(1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 1, 32'h0BADF00D);
    alu(1'b1, 1'b0, '0);
    alu(1'b0, 1'b0, '0);
    alu(1'b0, 1'b0, '0);

    // Read+write together: issued as a write, sticky error.
    do_mem(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'hA5A5A5A5, 1, 32'h11111111);
    alu(1'b1, 1'b0, '0);
    alu(1'b1, 1'b0, '0);

    // Reset in the middle of an access: abandoned, everything cleared.
    tick();
    ex_valid = 1'b1; ex_memRead = 1'b1; ex_memWrite = 1'b0; ex_addr = 32'h400;
    dbus.dhit = 1'b0;
    #1;
    tick();
    #1;
    chk("mid_dren", dbus.dREN, 1'b1);
    nRST = 1'b0;
    ex_valid = 1'b0;
    #1;
    chk("arst_dren",  dbus.dREN, 1'b0);
    chk("arst_stall", stall_up, 1'b0);
    chk("arst_daddr", dbus.daddr, 32'h0);
    chk("arst_load",  wb_dmemload, 32'h0);
    chk("arst_perr",  protocol_err, 1'b0);
    model_load = '0;
    model_perr = 1'b0;
    tick();
    nRST = 1'b1;
    alu(1'b1, 1'b0, '0);
    do_mem(1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 2, 32'h76543210);

    // Random instruction mix.
    for (int i = 0; i < 40; i++) begin
      int    kind;
      word_t a;
      kind = $urandom_range(0, 3);
      a    = $urandom & 32'hFFFF_FFFC;
      case (kind)
        0: alu(1'b1, 1'b0, '0);
        1: alu(1'b0, 1'b0, '0);
        2: do_mem(1'b1, 1'b0, 1'b0, 1'b0, a, $urandom, $urandom_range(1, 4), $urandom);
        default: do_mem(1'b0, 1'b1, 1'b0, 1'b0, a, $urandom, $urandom_range(1, 4), $urandom);
      endcase
    end

`ifdef LLSC_EN
    // LL/SC pair succeeds; a second SC finds the link consumed.
    do_mem(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1, 32'h33333333);
    do_mem(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h77, 1, 32'h0);
    sc_fail(32'h300, 1'b0);
    // Snoop between LL and SC breaks the link.
    do_mem(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 2, 32'h44444444);
    alu(1'b1, 1'b1, 32'h300);
    sc_fail(32'h300, 1'b0);
    // Snoop in the SC cycle itself wins.
    do_mem(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1, 32'h55555555);
    sc_fail(32'h300, 1'b1);
    // SC to a different address than the link fails.
    do_mem(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1, 32'h66666666);
    sc_fail(32'h304, 1'b0);
    alu(1'b1, 1'b0, '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: CLK is the clock and nRST is the reset.
REQ-002 SHALL have port CLK, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port nRST, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port ex_valid, input, 1 bit: EX/MEM entry holds a live instruction.
REQ-005 SHALL have ports ex_memRead and ex_memWrite, inputs, 1 bit each: load or store request.
REQ-006 SHALL have ports ex_addr and ex_storeData, inputs, 32 bits each: effective address and store word.
REQ-007 SHALL have ports dREN and dWEN, outputs, 1 bit each: data-cache read and write request.
REQ-008 SHALL have ports daddr and dstore, outputs, 32 bits each: registered cache address and store data.
REQ-009 SHALL have ports dhit (input, 1 bit) and dload (input, 32 bits): cache completion and load data.
REQ-010 SHALL have port wb_writeEN, output, 1 bit: drives the MEM/WB latch write enable.
REQ-011 SHALL have port wb_dmemload, output, 32 bits: load data toward MEM/WB dmemload_in.
REQ-012 SHALL have port stall_up, output, 1 bit: freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-013 SHALL have port protocol_err, output, 1 bit: sticky illegal-request flag.
REQ-014 SHALL have ports ex_ll and ex_sc (inputs, 1 bit), ccinv (input, 1 bit), ccsnoopaddr (input, 32 bits) and wb_scResult (output, 1 bit), present only under LLSC_EN.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-016 IDLE, non-memory or !ex_valid: SHALL drive wb_writeEN=1 and stall_up=0 in the same cycle, and remain in IDLE.
REQ-017 IDLE, memory request: SHALL drive stall_up=1 and wb_writeEN=0 combinationally, register daddr and dstore, and go to ACCESS.
REQ-018 ACCESS: SHALL hold dREN or dWEN at 1 with stall_up=1 and wb_writeEN=0; on dhit=1 it SHALL capture dload into wb_dmemload and go to DONE.
REQ-019 DONE: SHALL drive dREN=dWEN=0, wb_writeEN=1 and stall_up=0 for exactly one cycle, then go to IDLE; EX/MEM advances on that same edge, so there is no re-issue.
REQ-020 Minimum memory latency SHALL be 3 cycles (request seen at N, dhit at N+1, wb_writeEN at N+2); dhit stall length is unbounded.
REQ-021 dhit SHALL be ignored in IDLE and DONE.
REQ-022 ex_memRead and ex_memWrite both 1: SHALL be treated as a write, and protocol_err SHALL be set until reset.
REQ-023 wb_dmemload SHALL hold its last load value through stores and non-memory instructions.

Reset
REQ-024 nRST low at any time, including mid-ACCESS, SHALL asynchronously force: state=IDLE, dREN=dWEN=0, daddr=dstore=0, wb_dmemload=0, protocol_err=0, link cleared, wb_scResult=0.
REQ-025 A transaction interrupted by reset SHALL NOT be completed or retried.

Configuration
REQ-026 Macro LLSC_EN SHALL compile in load-linked/store-conditional support.
REQ-027 With LLSC_EN, LL SHALL behave as a load and, at DONE, set link_valid=1 and link_addr=ex_addr.
REQ-028 With LLSC_EN, SC with link_valid and address match SHALL perform the write, return wb_scResult=1 and clear the link.
REQ-029 With LLSC_EN, SC without a link match SHALL issue no cache access, return wb_scResult=0 and assert wb_writeEN in the IDLE cycle.
REQ-030 With LLSC_EN, a completed store to link_addr, or ccinv=1 with ccsnoopaddr==link_addr, SHALL clear the link; a snoop in the same cycle as SC evaluation SHALL take priority, so the SC fails.
REQ-031 Without LLSC_EN, the LL/SC and snoop ports and the link logic SHALL be absent.

Structure
REQ-032 word_t and the memstate_t enum (IDLE/ACCESS/DONE) SHALL live in cpu_types_pkg.
REQ-033 The link register SHALL be a sub-module link_reg, instantiated only under LLSC_EN.

Verification
REQ-034 Load at 0x100 with dload=0xDEADBEEF and dhit after 2 cycles -> dREN high for 2 cycles, stall_up high for 3, then wb_writeEN=1 with wb_dmemload=0xDEADBEEF.
REQ-035 Store 0x1234 to 0x200 with dhit=1 at first opportunity -> dWEN=1 one cycle, daddr=0x200, dstore=0x1234, wb_writeEN at N+2.
REQ-036 Back-to-back ALU, load, ALU -> ALU instructions see wb_writeEN=1 with zero stall; the load stalls exactly 2 cycles minimum.
REQ-037 nRST pulsed mid-ACCESS -> dREN drops immediately, state IDLE, and the next request is issued fresh.
REQ-038 (LLSC_EN) LL 0x300 then SC 0x300 -> wb_scResult=1; LL 0x300, ccinv with ccsnoopaddr=0x300, then SC -> wb_scResult=0 and no dWEN.
REQ-039 ex_memRead=ex_memWrite=1 -> write issued, protocol_err=1 and held until reset.
